// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct codes, FSM state and operation-kind encodings shared by the multiply/divide unit.
package muldiv_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // Encoded to match funct[1:0]: bit 1 selects divide, bit 0 set means unsigned.
    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULU = 2'b01,
        OP_DIV  = 2'b10,
        OP_DIVU = 2'b11
    } op_kind_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: unsigned shift-add multiplier / restoring divider, one bit per cycle.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_COUNT = 6
)(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  op_kind_t           i_op,
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    output logic               o_last,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);

    logic [NB_DATA-1:0]  r_acc, r_q, r_b;
    logic [NB_COUNT-1:0] r_cnt;
    logic                r_div;
    logic [NB_DATA:0]    w_add, w_shl, w_sub;

    // {acc,q} is the running product (mult) or {remainder,quotient/dividend} (div).
    assign w_add = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    assign w_shl = {r_acc, r_q[NB_DATA-1]};
    assign w_sub = w_shl - {1'b0, r_b};

    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) begin
            r_acc <= '0;
            r_q   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (i_start) begin
            r_acc <= '0;
            r_q   <= i_a;
            r_b   <= i_b;
            r_cnt <= NB_COUNT'(NB_DATA);
            r_div <= i_op == OP_DIV || i_op == OP_DIVU;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            r_acc <= r_div ? (w_sub[NB_DATA] ? w_shl[NB_DATA-1:0] : w_sub[NB_DATA-1:0]) : w_add[NB_DATA:1];
            r_q   <= r_div ? {r_q[NB_DATA-2:0], ~w_sub[NB_DATA]} : {w_add[0], r_q[NB_DATA-1:1]};
        end

    assign o_last = r_cnt == NB_COUNT'(1);
    assign o_hi   = r_acc;
    assign o_lo   = r_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/DIV with HI/LO registers and hazard stall for the EX stage.
// Define EX_MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they behave as MULTU/DIVU.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int NB_DATA        = 32,
    parameter int NB_ALU_OP      = 2,
    parameter int NB_INSTRUCCION = 6,
    parameter int NB_COUNT       = 6
)(
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic [NB_ALU_OP-1:0]      i_alu_op,
    input  logic [NB_INSTRUCCION-1:0] i_inst_funcion,
    input  logic [NB_DATA-1:0]        i_rs_data,
    input  logic [NB_DATA-1:0]        i_rt_data,
    output logic [NB_DATA-1:0]        o_hilo_data,
    output logic                      o_busy,
    output logic                      o_stall,
    output logic                      o_done
);

    state_t               r_state, w_next;
    op_kind_t             w_op;
    logic [NB_DATA-1:0]   r_hi, r_lo, w_abs_a, w_abs_b, w_core_hi, w_core_lo, w_quo, w_rem;
    logic [2*NB_DATA-1:0] w_prod;
    logic                 r_div, r_dz, r_done;
    logic                 w_rtype, w_md, w_hl, w_idle, w_fix, w_start, w_last;

    assign w_rtype = i_valid && i_alu_op == NB_ALU_OP'(ALU_OP_RTYPE);
    assign w_md    = w_rtype && (i_inst_funcion == FN_MULT || i_inst_funcion == FN_MULTU ||
                                 i_inst_funcion == FN_DIV  || i_inst_funcion == FN_DIVU);
    assign w_hl    = w_rtype && (i_inst_funcion == FN_MFHI || i_inst_funcion == FN_MTHI ||
                                 i_inst_funcion == FN_MFLO || i_inst_funcion == FN_MTLO);
    assign w_op    = op_kind_t'(i_inst_funcion[1:0]);
    assign w_idle  = r_state == ST_IDLE;
    assign w_fix   = r_state == ST_FIX;
    assign w_start = w_idle && w_md;

`ifdef EX_MULDIV_SIGNED_EN
    logic w_sgn, r_neg_q, r_neg_r;
    assign w_sgn   = w_op == OP_MUL || w_op == OP_DIV;
    assign w_abs_a = w_sgn && i_rs_data[NB_DATA-1] ? -i_rs_data : i_rs_data;
    assign w_abs_b = w_sgn && i_rt_data[NB_DATA-1] ? -i_rt_data : i_rt_data;
    assign w_prod  = r_neg_q ? -{w_core_hi, w_core_lo} : {w_core_hi, w_core_lo};
    assign w_quo   = r_neg_q ? -w_core_lo : w_core_lo;
    assign w_rem   = r_neg_r ? -w_core_hi : w_core_hi;
    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_start) begin
            r_neg_q <= w_sgn && (i_rs_data[NB_DATA-1] ^ i_rt_data[NB_DATA-1]);
            r_neg_r <= w_sgn && i_rs_data[NB_DATA-1];
        end
`else
    assign w_abs_a = i_rs_data;
    assign w_abs_b = i_rt_data;
    assign w_prod  = {w_core_hi, w_core_lo};
    assign w_quo   = w_core_lo;
    assign w_rem   = w_core_hi;
`endif

    muldiv_iter_core #(.NB_DATA(NB_DATA), .NB_COUNT(NB_COUNT)) u_core (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_start (w_start),
        .i_op    (w_op),
        .i_a     (w_abs_a),
        .i_b     (w_abs_b),
        .o_last  (w_last),
        .o_hi    (w_core_hi),
        .o_lo    (w_core_lo)
    );

    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;

    always_comb begin
        w_next  = w_idle ? (w_start ? ST_RUN : ST_IDLE) :
                  r_state == ST_RUN ? (w_last ? ST_FIX : ST_RUN) : ST_IDLE;
        o_busy  = !w_idle;
        o_stall = !w_idle && (w_md || w_hl);
    end

    // Divide by zero leaves the core remainder equal to the dividend, so only LO needs forcing.
    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_div  <= 1'b0;
            r_dz   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_start) begin
                r_div <= w_op == OP_DIV || w_op == OP_DIVU;
                r_dz  <= i_rt_data == '0;
            end
            if (w_fix)
                r_hi <= r_div ? w_rem : w_prod[2*NB_DATA-1:NB_DATA];
            else if (w_idle && w_rtype && i_inst_funcion == FN_MTHI)
                r_hi <= i_rs_data;
            if (w_fix)
                r_lo <= !r_div ? w_prod[NB_DATA-1:0] : r_dz ? '1 : w_quo;
            else if (w_idle && w_rtype && i_inst_funcion == FN_MTLO)
                r_lo <= i_rs_data;
        end

    assign o_done      = r_done;
    assign o_hilo_data = w_rtype && i_inst_funcion == FN_MFHI ? r_hi :
                         w_rtype && i_inst_funcion == FN_MFLO ? r_lo : '0;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized and directed checks of ex_muldiv_unit against a 64-bit arithmetic model.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        i_clock, i_reset, i_valid;
    logic [1:0]  i_alu_op;
    logic [5:0]  i_inst_funcion;
    logic [31:0] i_rs_data, i_rt_data, o_hilo_data;
    logic        o_busy, o_stall, o_done;
    int          checks, errors;

    localparam logic [5:0] FN_ADDU = 6'b100001;

    ex_muldiv_unit dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_valid        (i_valid),
        .i_alu_op       (i_alu_op),
        .i_inst_funcion (i_inst_funcion),
        .i_rs_data      (i_rs_data),
        .i_rt_data      (i_rt_data),
        .o_hilo_data    (o_hilo_data),
        .o_busy         (o_busy),
        .o_stall        (o_stall),
        .o_done         (o_done)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Returns {HI, LO} as the architecture defines them.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, rm;
        bit     sgn;
        sgn = 1'b0;
`ifdef EX_MULDIV_SIGNED_EN
        sgn = (f == FN_MULT || f == FN_DIV);
`endif
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (f == FN_MULT || f == FN_MULTU) return 64'(sa * sb);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q  = sa / sb;
        rm = sa % sb;
        return {rm[31:0], q[31:0]};
    endfunction

    task automatic cyc();
        @(posedge i_clock);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        i_valid = 1'b1;
        i_alu_op = 2'b10;
        i_inst_funcion = f;
        i_rs_data = a;
        i_rt_data = b;
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_alu_op = 2'b00;
        i_inst_funcion = 6'd0;
        i_rs_data = 32'd0;
        i_rt_data = 32'd0;
    endtask

    task automatic do_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int n;
        exp = model(f, a, b);
        issue(f, a, b);
        #1;
        checks++;
        if (o_stall !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: stall=%b busy=%b expected 0 0", name, o_stall, o_busy);
        end
        cyc();
        idle();
        n = 1;
        while (o_done !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        checks++;
        if (n !== 34) begin
            errors++;
            $display("FAIL %s latency: got %0d expected 34", name, n);
        end
        issue(FN_MFHI, 32'd0, 32'd0);
        #1;
        checks++;
        if (o_hilo_data !== exp[63:32] || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL %s HI: got %h stall=%b expected %h stall=0", name, o_hilo_data, o_stall, exp[63:32]);
        end
        issue(FN_MFLO, 32'd0, 32'd0);
        #1;
        checks++;
        if (o_hilo_data !== exp[31:0]) begin
            errors++;
            $display("FAIL %s LO: got %h expected %h", name, o_hilo_data, exp[31:0]);
        end
        cyc();
        idle();
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: o_done=%b expected 0", name, o_done);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        idle();
        repeat (2) cyc();
        issue(FN_MFHI, 32'd0, 32'd0);
        #1;
        checks++;
        if ({o_busy, o_stall, o_done} !== 3'b000 || o_hilo_data !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b stall=%b done=%b hilo=%h expected 0 0 0 0", o_busy, o_stall, o_done, o_hilo_data);
        end
        idle();
        i_reset = 1'b0;
        cyc();
    endtask

    task automatic test_directed();
        do_op("multu_7_6", FN_MULTU, 32'd7, 32'd6);
        do_op("mult_m3_5", FN_MULT, 32'hFFFF_FFFD, 32'd5);
        do_op("divu_100_7", FN_DIVU, 32'd100, 32'd7);
        do_op("div_m7_2", FN_DIV, 32'hFFFF_FFF9, 32'd2);
        do_op("divu_55_0", FN_DIVU, 32'd55, 32'd0);
        do_op("div_m8_0", FN_DIV, 32'hFFFF_FFF8, 32'd0);
        do_op("div_min_m1", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        logic [5:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            f = {4'b0110, 2'($urandom_range(0, 3))};
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = 32'd0;
                default: b = -$urandom_range(1, 15);
            endcase
            do_op($sformatf("rand%0d_f%b", i, f), f, a, b);
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp;
        int n;
        exp = model(FN_MULT, 32'hFFFF_FF00, 32'h0000_1234);
        issue(FN_MULT, 32'hFFFF_FF00, 32'h0000_1234);
        cyc();
        idle();
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL stall busy_run: got %b expected 1", o_busy);
        end
        cyc();
        issue(FN_ADDU, 32'd1, 32'd2);
        #1;
        checks++;
        if (o_stall !== 1'b0 || o_hilo_data !== 32'd0) begin
            errors++;
            $display("FAIL stall addu: stall=%b hilo=%h expected 0 0", o_stall, o_hilo_data);
        end
        cyc();
        n = 3;
        issue(FN_MFHI, 32'd0, 32'd0);
        #1;
        checks++;
        if (o_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall mfhi_busy: got %b expected 1", o_stall);
        end
        while (o_stall === 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        checks++;
        if (n !== 34 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL stall release: cycle %0d done=%b expected 34 1", n, o_done);
        end
        checks++;
        if (o_hilo_data !== exp[63:32]) begin
            errors++;
            $display("FAIL stall mfhi_data: got %h expected %h", o_hilo_data, exp[63:32]);
        end
        idle();
        cyc();
    endtask

    task automatic test_reset_mid();
        bit seen;
        issue(FN_MTHI, 32'h0000_1234, 32'd0);
        cyc();
        issue(FN_MTLO, 32'h0000_5678, 32'd0);
        cyc();
        issue(FN_MFHI, 32'd0, 32'd0);
        #1;
        checks++;
        if (o_hilo_data !== 32'h0000_1234) begin
            errors++;
            $display("FAIL reset_mid preload: got %h expected 00001234", o_hilo_data);
        end
        issue(FN_MULTU, 32'd7, 32'd6);
        cyc();
        idle();
        repeat (9) cyc();
        #2;
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy: got %b expected 0", o_busy);
        end
        issue(FN_MFHI, 32'd0, 32'd0);
        #1;
        checks++;
        if (o_hilo_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid hi: got %h expected 0", o_hilo_data);
        end
        issue(FN_MFLO, 32'd0, 32'd0);
        #1;
        checks++;
        if (o_hilo_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid lo: got %h expected 0", o_hilo_data);
        end
        idle();
        cyc();
        i_reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            cyc();
            if (o_done === 1'b1 || o_busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid no_done: activity seen after abort");
        end
    endtask

    task automatic test_mt_mf();
        logic [31:0] v;
        issue(FN_MTLO, 32'h0000_00A5, 32'd0);
        cyc();
        issue(FN_MFLO, 32'd0, 32'd0);
        #1;
        checks++;
        if (o_hilo_data !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL mtlo_a5: got %h expected 000000a5", o_hilo_data);
        end
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            issue(FN_MTHI, v, 32'd0);
            cyc();
            i_alu_op = 2'b00;
            i_inst_funcion = FN_MTHI;
            i_rs_data = ~v;
            cyc();
            i_alu_op = 2'b10;
            i_valid = 1'b0;
            cyc();
            issue(FN_MFHI, 32'd0, 32'd0);
            #1;
            checks++;
            if (o_hilo_data !== v) begin
                errors++;
                $display("FAIL mthi_gated%0d: got %h expected %h", i, o_hilo_data, v);
            end
            idle();
            cyc();
        end
        i_valid = 1'b0;
        i_alu_op = 2'b10;
        i_inst_funcion = FN_MULT;
        cyc();
        idle();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_mult: busy=%b expected 0", o_busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_reset_mid();
        test_mt_mf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
